// File: rtl/regbank_arbiter_if.sv
// Shared access bus between the requesters and the arbitrated register bank.
// Requesters drive the packed request fields; the bank returns grant and read data.
interface regbank_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16,
  parameter int AW    = 4,
  parameter int IDW   = 2
);
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       we;
  logic [NREQ*AW-1:0]    addr;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      rdata;
  logic                  rvalid;
  logic [IDW-1:0]        rid;
  logic                  busy;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rdata, rvalid, rid, busy
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rdata, rvalid, rid, busy
  );
endinterface

// File: rtl/regbank_arbiter.sv
// DEPTH x WIDTH register bank behind one port shared by NREQ requesters.
// Round-robin arbitration grants one read or write per cycle; reads return tagged with the requester ID.
module regbank_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int IDW   = 2
) (
  input logic           clk,
  input logic           rst,
  regbank_arbiter_if.slave bus
);

  logic [WIDTH-1:0] r_bank [DEPTH];
  logic [IDW-1:0]   r_ptr;
  logic [NREQ-1:0]  r_gnt;
  logic [WIDTH-1:0] r_rdata;
  logic             r_rvalid;
  logic [IDW-1:0]   r_rid;

  logic             w_found;
  logic [IDW-1:0]   w_win;
  logic [IDW-1:0]   w_idx;
  logic [AW-1:0]    w_addr;
  logic [WIDTH-1:0] w_wdata;
  logic             w_we;

  // Scan from r_ptr upward; IDW-bit addition wraps modulo NREQ since NREQ is a power of two.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_idx = r_ptr + IDW'(i);
      if (!w_found && bus.req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  // Only the winner's fields are selected, so unknowns on idle requesters never propagate.
  always_comb begin
    w_addr  = bus.addr[w_win*AW +: AW];
    w_wdata = bus.wdata[w_win*WIDTH +: WIDTH];
    w_we    = bus.we[w_win];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr    <= '0;
      r_gnt    <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_rid    <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        r_bank[k] <= '0;
      end
    end else begin
      r_rvalid <= 1'b0;
      if (w_found) begin
        r_gnt <= NREQ'(1) << w_win;
        r_ptr <= w_win + IDW'(1);
        if (w_we) begin
          r_bank[w_addr] <= w_wdata;
        end else begin
          r_rdata  <= r_bank[w_addr];
          r_rvalid <= 1'b1;
          r_rid    <= w_win;
        end
      end else begin
        r_gnt <= '0;
      end
    end
  end

  assign bus.gnt    = r_gnt;
  assign bus.rdata  = r_rdata;
  assign bus.rvalid = r_rvalid;
  assign bus.rid    = r_rid;
  assign bus.busy   = |(bus.req & ~r_gnt);

endmodule

// File: tb/tb_regbank_arbiter.sv
// Scoreboard bench for regbank_arbiter: a reference bank/arbiter model predicts grants,
// and expected read returns are queued at grant time and popped when the DUT returns them.
module tb_regbank_arbiter;

  logic clk;
  logic rst;

  regbank_arbiter_if #(.NREQ(4), .WIDTH(16), .AW(4), .IDW(2)) bus ();

  regbank_arbiter #(.NREQ(4), .WIDTH(16), .DEPTH(16), .AW(4), .IDW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] data;
  } rd_t;

  rd_t         sbq[$];
  logic [15:0] mbank [16];
  logic [1:0]  mptr;
  logic [15:0] m_rdata;
  logic [1:0]  m_rid;
  int          vectors;
  int          miscompares;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mbank[i] = 16'h0000;
    mptr    = 2'd0;
    m_rdata = 16'h0000;
    m_rid   = 2'd0;
    sbq.delete();
  endtask

  task automatic set_req(input int i, input bit w, input logic [3:0] a, input logic [15:0] d);
    bus.req[i]            = 1'b1;
    bus.we[i]             = w;
    bus.addr[i*4 +: 4]    = a;
    bus.wdata[i*16 +: 16] = d;
  endtask

  // One clock: predict from current inputs, clock, then compare everything.
  task automatic step(input bit auto_rel);
    bit          found;
    bit          erv;
    int          win;
    int          idx;
    logic [3:0]  eg;
    logic [3:0]  a;
    found = 1'b0;
    erv   = 1'b0;
    win   = 0;
    eg    = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      idx = (int'(mptr) + k) % 4;
      if (!found && bus.req[idx] === 1'b1) begin
        found = 1'b1;
        win   = idx;
      end
    end
    if (found) begin
      eg   = 4'b0001 << win;
      mptr = 2'(win + 1);
      a    = bus.addr[win*4 +: 4];
      if (bus.we[win]) begin
        mbank[a] = bus.wdata[win*16 +: 16];
      end else begin
        sbq.push_back({2'(win), mbank[a]});
        erv = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check("gnt", bus.gnt, eg);
    check("rvalid", bus.rvalid, erv);
    if (bus.rvalid === 1'b1 || erv) begin
      if (sbq.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        rd_t e;
        e       = sbq.pop_front();
        m_rdata = e.data;
        m_rid   = e.id;
      end
    end
    check("rdata", bus.rdata, m_rdata);
    check("rid", bus.rid, m_rid);
    check("busy", bus.busy, |(bus.req & ~eg));
    if (auto_rel && found) bus.req[win] = 1'b0;
  endtask

  // Called #1 after an edge: assert rst mid-cycle and check outputs before any clock edge.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    check("rst_gnt", bus.gnt, 4'b0000);
    check("rst_rvalid", bus.rvalid, 1'b0);
    check("rst_rdata", bus.rdata, 16'h0000);
    check("rst_rid", bus.rid, 2'd0);
    model_reset();
    bus.req = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] pre [4];
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    bus.req     = '0;
    bus.we      = '0;
    bus.addr    = 'x;
    bus.wdata   = 'x;
    model_reset();
    pre[0] = 16'h0011; pre[1] = 16'h0022; pre[2] = 16'h0033; pre[3] = 16'h0044;

    @(posedge clk);
    @(negedge clk);
    check("init_gnt", bus.gnt, 4'b0000);
    check("init_rvalid", bus.rvalid, 1'b0);
    rst = 1'b0;

    // All 16 addresses read back zero after reset
    for (int a = 0; a < 16; a++) begin
      set_req(0, 1'b0, 4'(a), 16'h0000);
      step(1'b1);
      check("init_rd", bus.rdata, 16'h0000);
    end

    // Single write then read
    set_req(0, 1'b1, 4'd5, 16'hBEEF);
    step(1'b1);
    check("wr_gnt", bus.gnt, 4'b0001);
    set_req(0, 1'b0, 4'd5, 16'h0000);
    step(1'b1);
    check("rd_gnt", bus.gnt, 4'b0001);
    check("beef_rvalid", bus.rvalid, 1'b1);
    check("beef_rdata", bus.rdata, 16'hBEEF);
    check("beef_rid", bus.rid, 2'd0);

    // Preload 1..4; last write from requester 3 leaves ptr at 0
    for (int a = 1; a <= 3; a++) begin
      set_req(0, 1'b1, 4'(a), pre[a-1]);
      step(1'b1);
    end
    set_req(3, 1'b1, 4'd4, pre[3]);
    step(1'b1);

    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 4'(i + 1), 16'h0000);
    for (int k = 0; k < 4; k++) begin
      step(1'b1);
      check("rr4_gnt", bus.gnt, 4'b0001 << k);
      check("rr4_rdata", bus.rdata, pre[k]);
      check("rr4_rid", bus.rid, 32'(k));
    end

    // Move ptr to 3, then hold req3 and req0 continuously
    set_req(2, 1'b0, 4'd0, 16'h0000);
    step(1'b1);
    set_req(3, 1'b0, 4'd2, 16'h0000);
    set_req(0, 1'b0, 4'd3, 16'h0000);
    for (int k = 0; k < 4; k++) begin
      step(1'b0);
      check("fair_gnt", bus.gnt, (k % 2 == 0) ? 4'b1000 : 4'b0001);
    end
    bus.req = '0;

    // Read-after-write, same cycle request, ptr=1
    set_req(1, 1'b1, 4'd15, 16'h1234);
    set_req(2, 1'b0, 4'd15, 16'h0000);
    step(1'b1);
    check("raw_wgnt", bus.gnt, 4'b0010);
    step(1'b1);
    check("raw_rgnt", bus.gnt, 4'b0100);
    check("raw_rdata", bus.rdata, 16'h1234);
    check("raw_rid", bus.rid, 2'd2);

    // Reset while req0's write is pending behind req3 (ptr=3)
    set_req(0, 1'b1, 4'd7, 16'hAAAA);
    set_req(3, 1'b0, 4'd0, 16'h0000);
    step(1'b1);
    check("rstop_gnt", bus.gnt, 4'b1000);
    check("rstop_busy", bus.busy, 1'b1);
    async_reset();
    set_req(0, 1'b0, 4'd7, 16'h0000);
    set_req(3, 1'b0, 4'd1, 16'h0000);
    step(1'b1);
    check("post_rst_gnt", bus.gnt, 4'b0001);
    check("post_rst_bank7", bus.rdata, 16'h0000);
    step(1'b1);
    check("post_rst_gnt2", bus.gnt, 4'b1000);
    for (int a = 0; a < 16; a++) begin
      set_req(1, 1'b0, 4'(a), 16'h0000);
      step(1'b1);
      check("rst_rd", bus.rdata, 16'h0000);
    end

    // Random contention
    for (int n = 0; n < 80; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.req[i] !== 1'b1 && $urandom_range(0, 1) == 1)
          set_req(i, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom));
      end
      step(1'b1);
    end
    bus.req = '0;
    step(1'b1);
    step(1'b1);
    check("sb_empty", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regbank_arbiter.md
Name: regbank_arbiter

Overview:
- Bank of DEPTH x WIDTH registers with a single shared access port.
- NREQ requesters (CPU core, DMA, debug, I/O) contend for the port through round-robin arbitration.
- One access is granted per cycle: either a read or a write.
- Read data comes from the 16:1 word select. It is returned registered, tagged with the ID of the requester that issued the read.

Parameters:
- NREQ, 4, number of requesters (power of two; 2..8).
- WIDTH, 16, register word width.
- DEPTH, 16, number of registers.
- AW, 4, address width (log2 DEPTH).
- IDW, 2, requester-ID width (log2 NREQ).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester access request.
- we  in  NREQ  per-requester write enable; 1 = write, 0 = read.
- addr  in  NREQ*AW  packed addresses; requester i at [i*AW +: AW].
- wdata  in  NREQ*WIDTH  packed write data; requester i at [i*WIDTH +: WIDTH].
- gnt  out  NREQ  one-hot grant pulse, registered.
- rdata  out  WIDTH  read data, registered.
- rvalid  out  1  rdata valid pulse.
- rid  out  IDW  index of the requester that owns rdata.
- busy  out  1  1 while any req is pending and unserved.

Behaviour:
- Reset (async, rst=1):
  - All bank registers = 0.
  - gnt = 0, rdata = 0, rvalid = 0, rid = 0.
  - Priority pointer ptr = 0.
  - Takes effect immediately, not at the next edge.
- Arbitration (combinational, cycle N):
  - Scan req starting at index ptr, then ptr+1, ... wrapping modulo NREQ.
  - The first set bit is the winner w.
  - No req set: no winner; ptr holds.
- Edge ending cycle N, with a winner:
  - gnt = one-hot(w) for cycle N+1 only; gnt is 0 in any cycle with no winner in the previous cycle.
  - ptr <= (w+1) mod NREQ.
  - If we[w]=1: bank[addr_w] <= wdata_w; rvalid <= 0.
  - If we[w]=0: rdata <= bank[addr_w] (pre-edge contents); rvalid <= 1; rid <= w.
- Latency:
  - Request raised in cycle N with no competition: gnt and rdata/rvalid visible in cycle N+1.
  - Uncontended throughput: one access per cycle.
- Requester protocol:
  - Hold req/we/addr/wdata stable until gnt seen.
  - Sample rdata when rvalid=1 and rid = own index.
  - If req is still 1 in the gnt cycle, that is a new request and is arbitrated normally.
- Fairness: a continuously requesting requester waits at most NREQ-1 grants to other requesters.
- Hold behaviour: rdata and rid hold their last value when rvalid=0. rvalid is a single-cycle pulse per read.
- Read-after-write, same address:
  - Write granted in N, read granted in N+1: rdata in N+2 returns the new value.
  - No bypass is needed, since only one access is granted per cycle.
- busy = |(req & ~gnt), combinational from req and the registered gnt.
- Address range: all addresses 0..DEPTH-1 are valid. Address width equals AW, so no out-of-range case exists.
- Reset mid-operation:
  - Any pending request is dropped; no write occurs on the reset cycle.
  - After rst falls, arbitration restarts from ptr=0.
- Unknown/X on inputs of non-winning requesters must not affect any output.

Test Plan:
- Reset values: assert rst mid-simulation without a clock edge.
  -> gnt=0, rvalid=0, rdata=0, rid=0 immediately.
  -> Subsequent reads of all 16 addresses return 0x0000.
- Single write then read: req0 writes 0xBEEF to addr 5 in cycle 1, then reads addr 5 in cycle 2.
  -> gnt=0001 in cycles 2 and 3.
  -> rvalid=1, rdata=0xBEEF, rid=0 in cycle 3.
- Four simultaneous reads of addrs 1,2,3,4 (preloaded 0x0011,0x0022,0x0033,0x0044), ptr=0, each requester holding req until granted.
  -> Grants 0,1,2,3 in consecutive cycles.
  -> rdata sequence 0x0011,0x0022,0x0033,0x0044 with rid 0..3.
- Pointer wrap/fairness: req3 and req0 held continuously after ptr=3.
  -> Grants alternate 3,0,3,0.
  -> Neither requester waits more than 1 grant.
- Back-to-back RAW: req1 writes 0x1234 to addr 15, req2 reads addr 15, both raised the same cycle with ptr=1.
  -> Write granted first.
  -> Read returns rdata=0x1234, rid=2 one cycle later.
- Reset mid-operation: rst pulsed while req0 write of 0xAAAA to addr 7 is pending but ungranted.
  -> bank[7] remains 0.
  -> After rst falls, first grant follows ptr=0 priority.
